spi_cmd_bridge: RTL

SPI_CMD_BRIDGE -- requirements
Module: spi_cmd_bridge

---
 rtl/spi_cmd_bridge.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_bridge.sv
// SPI command bridge: turns framed SPI bytes (header, address high, address low, data...)
// into single-beat register-bus reads and writes. Read data is prefetched so the SPI
// slave always has the next byte ready before the master clocks out the following one.
module spi_cmd_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned RW_BIT      = 7
) (
  input  logic        clk6x,
  input  logic        resetn,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_hdr_en_i,
  input  logic        rx_db_en_i,
  output logic [7:0]  tx_byte_o,
  output logic        tx_en_o,
  output logic [15:0] bus_addr_o,
  output logic [7:0]  bus_wdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  input  logic [7:0]  bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        err_ovr_o,
  output logic        err_tmo_o
);

  // The timeout counter runs 0 .. TIMEOUT_CYC-1 while a request is outstanding.
  localparam int unsigned    CntW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAddrH,
    StAddrL,
    StData,
    StBus,
    StDrain
  } state_e;

  state_e          state_q;
  logic [7:0]      hdr_q;
  logic [15:0]     bus_addr_q;
  logic [7:0]      bus_wdata_q;
  logic            bus_req_q;
  logic            bus_we_q;
  logic [7:0]      tx_byte_q;
  logic            tx_en_q;
  logic            err_ovr_q;
  logic            err_tmo_q;
  logic [CntW-1:0] tmo_cnt_q;

  logic [7:0] hdr_next;
  logic       hdr_next_clr;
  logic       hdr_rw;
  logic       hdr_ainc;
  logic       tmo_hit;
  logic       bus_done;
  logic       discard;

  // Decode the active/incoming header and the bus completion conditions.
  always_comb begin
    // A header arriving this cycle takes precedence over the latched one; while a request
    // is in flight the latched header already holds the pending (next) frame's header.
    hdr_next     = rx_hdr_en_i ? rx_byte_i : hdr_q;
    hdr_next_clr = &hdr_next[RW_BIT-1:1];
    hdr_rw       = hdr_q[RW_BIT];
    hdr_ainc     = hdr_q[0];
    tmo_hit      = (tmo_cnt_q == CntLast) && !bus_ack_i;
    bus_done     = bus_ack_i || tmo_hit;
    // Result of the in-flight request is thrown away once a new frame has started.
    discard      = (state_q == StDrain) || rx_hdr_en_i;
  end

  // Frame FSM with registered bus, tx and status outputs.
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      hdr_q       <= 8'h00;
      bus_addr_q  <= 16'h0000;
      bus_wdata_q <= 8'h00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      tx_byte_q   <= 8'h00;
      tx_en_q     <= 1'b0;
      err_ovr_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      tx_en_q <= 1'b0;
      case (state_q)
        StIdle, StAddrH, StAddrL, StData: begin
          if (rx_hdr_en_i) begin
            hdr_q <= rx_byte_i;
            if (hdr_next_clr) begin
              err_ovr_q <= 1'b0;
              err_tmo_q <= 1'b0;
              state_q   <= StIdle;
            end else begin
              state_q <= StAddrH;
            end
          end else if (rx_db_en_i) begin
            if (state_q == StAddrH) begin
              bus_addr_q[15:8] <= rx_byte_i;
              state_q          <= StAddrL;
            end else if (state_q == StAddrL) begin
              bus_addr_q[7:0] <= rx_byte_i;
              if (hdr_rw) begin
                // Prefetch the first read so tx data is ready before the first dummy byte.
                bus_req_q <= 1'b1;
                bus_we_q  <= 1'b0;
                tmo_cnt_q <= '0;
                state_q   <= StBus;
              end else begin
                state_q <= StData;
              end
            end else if (state_q == StData) begin
              // Writes carry the byte; for reads it is a dummy that triggers the next fetch.
              if (!hdr_rw) begin
                bus_wdata_q <= rx_byte_i;
              end
              bus_req_q <= 1'b1;
              bus_we_q  <= ~hdr_rw;
              tmo_cnt_q <= '0;
              state_q   <= StBus;
            end
          end
        end

        StBus, StDrain: begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          // Bytes arriving mid-request cannot be buffered; flag and drop them.
          if (state_q == StBus && rx_db_en_i) begin
            err_ovr_q <= 1'b1;
          end
          if (rx_hdr_en_i) begin
            hdr_q <= rx_byte_i;
          end
          if (bus_done) begin
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            if (tmo_hit) begin
              err_tmo_q <= 1'b1;
            end
            if (discard) begin
              // Pending header takes effect now; a clear command overrides a fresh timeout.
              if (hdr_next_clr) begin
                err_ovr_q <= 1'b0;
                err_tmo_q <= 1'b0;
                state_q   <= StIdle;
              end else begin
                state_q <= StAddrH;
              end
            end else begin
              state_q <= StData;
              if (hdr_rw) begin
                tx_byte_q <= tmo_hit ? 8'hFF : bus_rdata_i;
                tx_en_q   <= 1'b1;
              end
              // A timed-out access is retried at the same address by the next byte.
              if (bus_ack_i && hdr_ainc) begin
                bus_addr_q <= bus_addr_q + 16'd1;
              end
            end
          end else if (rx_hdr_en_i) begin
            state_q <= StDrain;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_byte_o   = tx_byte_q;
  assign tx_en_o     = tx_en_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign err_ovr_o   = err_ovr_q;
  assign err_tmo_o   = err_tmo_q;

endmodule
